spi_serf: RTL and testbench

SPI responder (serf) that pairs with the team's 16-bit SPI monarch on the same four-wire bus. It synchronizes SS_n, SCLK, and MOSI into the core clock domain. It shifts a 16-bit command in while shifting a pre-loaded 16-bit response out, and flags each frame as complete or malformed. It sits on the peripheral side, for example in sensor models and test-bench responders.

---
 rtl/spi_serf_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_serf.sv | 133 +++++++++++++
 tb/tb_spi_serf.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/spi_serf_pkg.sv
// spi_pkg: shared definitions for the SPI serf block.
//   state_t      - frame state machine encoding (IDLE, SHIFT)
//   SPI_WIDTH    - frame length in bits (fixed at 16 to match the monarch)
//   SYNC_STAGES  - flops per input synchronizer
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int SPI_WIDTH   = 16;
  localparam int SYNC_STAGES = 3;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for one asynchronous pin, with edge
// detection on the last two stages.
//   clk, rst  - core clock, asynchronous active-high reset
//   i_d       - raw asynchronous input
//   o_sync    - last synchronizer stage
//   o_rise    - one-cycle pulse on a 0->1 transition
//   o_fall    - one-cycle pulse on a 1->0 transition
// RST_VAL is the value every stage takes in reset, so an idle-high pin does
// not produce a spurious edge when reset is released.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  // r_sync[0] is stage 1 (metastable), r_sync[SYNC_STAGES-1] is the last stage.
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise =  r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
  assign o_fall = ~r_sync[SYNC_STAGES-2] &  r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_serf.sv
// spi_serf: SPI responder paired with the 16-bit SPI monarch (SCLK idle high,
// MSB first). Shifts a command in on MOSI while returning a pre-loaded word
// on MISO, and flags each frame as complete (rdy) or malformed (err).
//   clk, rst  - core clock, asynchronous active-high reset
//   SS_n      - active-low frame select (asynchronous)
//   SCLK      - serial clock (asynchronous)
//   MOSI      - serial data in (asynchronous)
//   MISO      - serial data out; 0 while deselected
//   tx_data   - response word, latched by wrt
//   wrt       - one-cycle load strobe for tx_data
//   rx_data   - last correctly received command
//   rdy       - a 16-bit frame was received; cleared by clr_rdy or next frame
//   clr_rdy   - clears rdy
//   err       - last frame had the wrong bit count
//   o_state   - current state (debug)
//
// Valid/ready: wrt is a one-cycle strobe and always accepted. rdy is a level
// that stays high until clr_rdy or the start of the next frame; a rdy set and
// a clr_rdy in the same cycle leave rdy set.
module spi_serf
  import spi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 SCLK,
  input  logic                 MOSI,
  output logic                 MISO,
  input  logic [SPI_WIDTH-1:0] tx_data,
  input  logic                 wrt,
  output logic [SPI_WIDTH-1:0] rx_data,
  output logic                 rdy,
  input  logic                 clr_rdy,
  output logic                 err,
  output logic                 o_state
);

  logic w_ss_sync, w_ss_rise, w_ss_fall;
  logic w_sclk_sync_unused, w_sclk_rise, w_sclk_fall;
  logic w_mosi_sync, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (SS_n),
    .o_sync (w_ss_sync),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (SCLK),
    .o_sync (w_sclk_sync_unused),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // Same depth as SCLK so the MOSI value seen with sclk_rise was sampled
  // before the monarch moves MOSI (2 clk after its SCLK rise).
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (MOSI),
    .o_sync (w_mosi_sync),
    .o_rise (w_mosi_rise_unused),
    .o_fall (w_mosi_fall_unused)
  );

  state_t               r_state;
  logic [SPI_WIDTH-1:0] r_tx_buf;
  logic [SPI_WIDTH-1:0] r_shft;
  logic [4:0]           r_bit_cnt;
  logic                 r_miso;
  logic [SPI_WIDTH-1:0] r_rx_data;
  logic                 r_rdy;
  logic                 r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tx_buf  <= '0;
      r_shft    <= '0;
      r_bit_cnt <= '0;
      r_miso    <= 1'b0;
      r_rx_data <= '0;
      r_rdy     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // tx_buf is only written here; shifting works on a copy in r_shft so
      // the same response repeats until the next wrt.
      if (wrt) r_tx_buf <= tx_data;

      // Later assignments below (a rdy set) override this clear.
      if (clr_rdy) r_rdy <= 1'b0;

      // A fall of SS_n starts a frame from either state; in SHIFT this is a
      // select glitch and the frame restarts.
      if (w_ss_fall) begin
        r_state   <= SHIFT;
        r_miso    <= r_tx_buf[SPI_WIDTH-1];
        r_shft    <= r_tx_buf;
        r_bit_cnt <= '0;
        r_err     <= 1'b0;
        r_rdy     <= 1'b0;
      end else if (r_state == SHIFT) begin
        if (w_ss_rise) begin
          if (r_bit_cnt == 5'd16) begin
            r_rx_data <= r_shft;
            r_rdy     <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
          r_state <= IDLE;
        end else if (w_sclk_rise) begin
          r_shft <= {r_shft[SPI_WIDTH-2:0], w_mosi_sync};
          if (r_bit_cnt != 5'd17) r_bit_cnt <= r_bit_cnt + 5'd1;
        end else if (w_sclk_fall && (r_bit_cnt != 5'd0)) begin
          // The monarch's first edge is a fall; MSB is already on MISO then.
          r_miso <= r_shft[SPI_WIDTH-1];
        end
      end
    end
  end

  assign MISO    = w_ss_sync ? 1'b0 : r_miso;
  assign rx_data = r_rx_data;
  assign rdy     = r_rdy;
  assign err     = r_err;
  assign o_state = r_state;

endmodule

// File: tb/tb_spi_serf.sv
module tb_spi_serf;
  import spi_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        SS_n, SCLK, MOSI, MISO;
  logic [15:0] tx_data, rx_data;
  logic        wrt, rdy, clr_rdy, err, o_state;

  spi_serf dut (
    .clk     (clk),
    .rst     (rst),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .tx_data (tx_data),
    .wrt     (wrt),
    .rx_data (rx_data),
    .rdy     (rdy),
    .clr_rdy (clr_rdy),
    .err     (err),
    .o_state (o_state)
  );

  int total = 0;
  int bad   = 0;

  // reference model: what the serf should report, from the frame rules
  logic [15:0] m_tx;     // word most recently written
  logic [15:0] m_rx;     // last good command
  logic        m_rdy;
  logic        m_err;
  logic [15:0] exp_q[$]; // expected monarch responses, one per frame

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver tasks
  task automatic do_wrt(input logic [15:0] w);
    tx_data = w; wrt = 1'b1; wait_clk(1); wrt = 1'b0;
    m_tx = w;
  endtask

  task automatic do_clr;
    clr_rdy = 1'b1; wait_clk(1); clr_rdy = 1'b0; wait_clk(1);
    m_rdy = 1'b0;
    check("clr_rdy", {15'd0, rdy}, {15'd0, m_rdy});
  endtask

  // Monarch: SCLK idle high, half period 16 clk, first edge a fall.
  // MOSI changes and MISO is sampled 2 clk after each SCLK rise.
  // rst_at >= 0 aborts the frame with rst held high after that many bits.
  task automatic monarch(input logic [15:0] cmd, input int nbits, input int wrt_at,
                         input logic [15:0] wrt_word, input int rst_at,
                         output logic [15:0] resp);
    resp = '0;
    SS_n = 1'b0;
    MOSI = cmd[15];
    wait_clk(16);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        SCLK = 1'b1; SS_n = 1'b1; MOSI = 1'b0; rst = 1'b1;
        wait_clk(2);
        return;
      end
      if (i == wrt_at) do_wrt(wrt_word);
      SCLK = 1'b0;
      wait_clk(16);
      SCLK = 1'b1;
      wait_clk(2);
      resp = {resp[14:0], MISO};
      if (i + 1 < 16) MOSI = cmd[14 - i];
      else            MOSI = 1'($urandom_range(0, 1));
      wait_clk(14);
    end
    wait_clk(8);
    SS_n = 1'b1;
    wait_clk(8);
  endtask

  // Full frame plus scoreboard update and checks.
  task automatic run_frame(input string tag, input logic [15:0] cmd, input int nbits,
                           input int wrt_at, input logic [15:0] wrt_word);
    logic [15:0] resp;
    logic [15:0] tx_start;
    tx_start = m_tx;
    monarch(cmd, nbits, wrt_at, wrt_word, -1, resp);
    // frame start clears rdy/err; end decides on bit count
    m_rdy = 1'b0;
    m_err = 1'b0;
    if (nbits == 16) begin
      m_rx  = cmd;
      m_rdy = 1'b1;
      exp_q.push_back(tx_start);
    end else begin
      m_err = 1'b1;
      if (nbits < 16) exp_q.push_back(tx_start >> (16 - nbits));
    end
    check({tag, ".rx"},  rx_data, m_rx);
    check({tag, ".rdy"}, {15'd0, rdy}, {15'd0, m_rdy});
    check({tag, ".err"}, {15'd0, err}, {15'd0, m_err});
    if (nbits <= 16) check({tag, ".resp"}, resp, exp_q.pop_front());
    check({tag, ".miso_idle"}, {15'd0, MISO}, 16'd0);
    check({tag, ".state"}, {15'd0, o_state}, {15'd0, IDLE});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".miso"},  {15'd0, MISO}, 16'd0);
    check({tag, ".rx"},    rx_data, 16'd0);
    check({tag, ".rdy"},   {15'd0, rdy}, 16'd0);
    check({tag, ".err"},   {15'd0, err}, 16'd0);
    check({tag, ".state"}, {15'd0, o_state}, {15'd0, IDLE});
  endtask

  initial begin
    logic [15:0] dummy;
    logic [15:0] w;
    int          nb;

    SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wrt = 1'b0; clr_rdy = 1'b0; tx_data = '0;
    m_tx = '0; m_rx = '0; m_rdy = 1'b0; m_err = 1'b0;
    rst = 1'b1;
    wait_clk(3);
    check_all_zero("reset");
    rst = 1'b0;
    wait_clk(4);
    check_all_zero("post_reset");

    // loopback
    do_wrt(16'hA5C3);
    run_frame("loopback", 16'h3C5A, 16, -1, '0);

    // back-to-back frames without a new wrt
    do_clr();
    run_frame("b2b_1", 16'h0001, 16, -1, '0);
    do_clr();
    run_frame("b2b_2", 16'h8000, 16, -1, '0);

    // short frame, then a good frame clears err
    run_frame("short", 16'h1234, 9, -1, '0);
    run_frame("after_short", 16'h5AA5, 16, -1, '0);

    // long frame
    run_frame("long", 16'h0F0F, 17, -1, '0);

    // reset mid-frame
    monarch(16'hDEAD, 16, -1, '0, 8, dummy);
    m_tx = '0; m_rx = '0; m_rdy = 1'b0; m_err = 1'b0;
    check_all_zero("rst_mid_held");
    rst = 1'b0;
    wait_clk(6);
    check_all_zero("rst_mid_after");
    run_frame("after_rst", 16'hBEEF, 16, -1, '0);

    // wrt during SHIFT only affects the next frame
    do_wrt(16'h1111);
    run_frame("wrt_mid", 16'h2222, 16, 8, 16'hFFFF);
    run_frame("wrt_next", 16'h3333, 16, -1, '0);

    // randomized frames
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        w = 16'($urandom);
        do_wrt(w);
      end
      if ($urandom_range(0, 2) == 0) do_clr();
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 16;
      run_frame("rand", 16'($urandom), nb, -1, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
